// File: rtl/mfcc_pkg.sv
// Shared MFCC front-end constants, derived index widths, power width helper and FSM states.
// Pure declarations: no latency, no flow control.
package mfcc_pkg;

    localparam int NUM_MEL_FILTERS_DEF = 40;
    localparam int NUM_DFT_POINTS_DEF  = 256;
    localparam int MEL_IDX_W           = $clog2(NUM_MEL_FILTERS_DEF);
    localparam int BIN_IDX_W           = $clog2(NUM_DFT_POINTS_DEF);

    // |X|^2 of two signed in_width components never exceeds 2^(2*in_width-1)
    function automatic int power_width(input int in_width);
        return 2 * in_width;
    endfunction

    typedef enum logic {
        W_FILL = 1'b0,
        W_FULL = 1'b1
    } wr_state_e;

    typedef enum logic {
        R_IDLE   = 1'b0,
        R_REPLAY = 1'b1
    } rd_state_e;

endpackage

// File: rtl/spectrum_bank_ram.sv
// Simple dual-port ping-pong spectrum store; bank select is the address MSB.
// Read latency 1 cycle; one write and one read per cycle, no backpressure.
module spectrum_bank_ram #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/dft_replay_buffer.sv
// Squares FFT bins into a ping-pong bank, then replays each frame NUM_MEL_FILTERS times back-to-back.
// Latency: last accepted bin -> first dft_valid is 3 cycles when the replay side is idle.
// Backpressure: bin_ready drops while one bank is full and the other is still replaying.
// Optional DFT_REPLAY_FRAME_ID_EN adds frame_id and pass_idx outputs.
module dft_replay_buffer
    import mfcc_pkg::*;
#(
    parameter int NUM_MEL_FILTERS = NUM_MEL_FILTERS_DEF,
    parameter int NUM_DFT_POINTS  = NUM_DFT_POINTS_DEF,
    parameter int IN_WIDTH        = 16,
    parameter int OUT_WIDTH       = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic signed [IN_WIDTH-1:0] bin_re,
    input  logic signed [IN_WIDTH-1:0] bin_im,
    input  logic                       bin_valid,
    input  logic                       bin_last,
    output logic                       bin_ready,
    output logic [OUT_WIDTH-1:0]       dft_out,
    output logic                       dft_valid,
    output logic                       replay_busy,
    output logic                       sync_err
`ifdef DFT_REPLAY_FRAME_ID_EN
    ,
    output logic [7:0]                 frame_id,
    output logic [$clog2(NUM_MEL_FILTERS)-1:0] pass_idx
`endif
);

    localparam int BW = $clog2(NUM_DFT_POINTS);
    localparam int MW = $clog2(NUM_MEL_FILTERS);
    localparam int PW = power_width(IN_WIDTH);
    localparam logic [BW-1:0] LAST_BIN  = BW'(NUM_DFT_POINTS - 1);
    localparam logic [MW-1:0] LAST_PASS = MW'(NUM_MEL_FILTERS - 1);

    wr_state_e             wstate_q, wstate_d;
    rd_state_e             rstate_q, rstate_d;
    logic [BW-1:0]         widx_q, widx_d;
    logic [BW-1:0]         bin_cnt_q, bin_cnt_d;
    logic [MW-1:0]         pass_cnt_q, pass_cnt_d;
    logic                  wbank_q, rbank_q;
    logic                  ready_q, sync_err_q, sync_err_d;
    logic                  pwr_vld_q, rd_vld_q;
    logic [OUT_WIDTH-1:0]  pwr_q, ram_rdata;
    logic [BW:0]           pwr_addr_q;
    logic signed [PW-1:0]  re_sq, im_sq;
    logic [PW:0]           pwr_full;
    logic                  accept, swap;

    assign re_sq    = PW'(bin_re) * PW'(bin_re);
    assign im_sq    = PW'(bin_im) * PW'(bin_im);
    assign pwr_full = {1'b0, re_sq} + {1'b0, im_sq};

    assign accept = bin_valid & ready_q;
    assign swap   = (wstate_q == W_FULL) && (rstate_q == R_IDLE);

    always_comb begin
        wstate_d   = wstate_q;
        widx_d     = widx_q;
        sync_err_d = 1'b0;
        if (accept) begin
            // A frame ends on count; bin_last only flags alignment
            sync_err_d = bin_last ^ (widx_q == LAST_BIN);
            if (widx_q == LAST_BIN) begin
                widx_d   = '0;
                wstate_d = W_FULL;
            end else if (bin_last) begin
                widx_d = '0;
            end else begin
                widx_d = widx_q + 1'b1;
            end
        end
        if (swap) begin
            wstate_d = W_FILL;
        end
    end

    always_comb begin
        rstate_d   = rstate_q;
        bin_cnt_d  = bin_cnt_q;
        pass_cnt_d = pass_cnt_q;
        if (rstate_q == R_REPLAY) begin
            if (bin_cnt_q == LAST_BIN) begin
                bin_cnt_d = '0;
                if (pass_cnt_q == LAST_PASS) begin
                    pass_cnt_d = '0;
                    rstate_d   = R_IDLE;
                end else begin
                    pass_cnt_d = pass_cnt_q + 1'b1;
                end
            end else begin
                bin_cnt_d = bin_cnt_q + 1'b1;
            end
        end else if (swap) begin
            rstate_d   = R_REPLAY;
            bin_cnt_d  = '0;
            pass_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wstate_q   <= W_FILL;
            rstate_q   <= R_IDLE;
            widx_q     <= '0;
            bin_cnt_q  <= '0;
            pass_cnt_q <= '0;
            wbank_q    <= 1'b0;
            rbank_q    <= 1'b0;
            ready_q    <= 1'b0;
            sync_err_q <= 1'b0;
            pwr_vld_q  <= 1'b0;
            pwr_q      <= '0;
            pwr_addr_q <= '0;
            rd_vld_q   <= 1'b0;
        end else begin
            wstate_q   <= wstate_d;
            rstate_q   <= rstate_d;
            widx_q     <= widx_d;
            bin_cnt_q  <= bin_cnt_d;
            pass_cnt_q <= pass_cnt_d;
            ready_q    <= (wstate_d == W_FILL);
            sync_err_q <= sync_err_d;
            pwr_vld_q  <= accept;
            rd_vld_q   <= (rstate_q == R_REPLAY);
            if (accept) begin
                // Top bit of the full-precision sum is always zero
                pwr_q      <= OUT_WIDTH'(PW'(pwr_full));
                pwr_addr_q <= {wbank_q, widx_q};
            end
            if (swap) begin
                rbank_q <= wbank_q;
                wbank_q <= ~wbank_q;
            end
        end
    end

    spectrum_bank_ram #(
        .ADDR_W (BW + 1),
        .DATA_W (OUT_WIDTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (pwr_vld_q),
        .waddr_i (pwr_addr_q),
        .wdata_i (pwr_q),
        .raddr_i ({rbank_q, bin_cnt_q}),
        .rdata_o (ram_rdata)
    );

    assign bin_ready   = ready_q;
    assign dft_valid   = rd_vld_q;
    assign dft_out     = rd_vld_q ? ram_rdata : '0;
    assign replay_busy = (rstate_q == R_REPLAY) | rd_vld_q;
    assign sync_err    = sync_err_q;

`ifdef DFT_REPLAY_FRAME_ID_EN
    logic [7:0]    frame_id_q;
    logic [MW-1:0] pass_idx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_id_q <= '0;
            pass_idx_q <= '0;
        end else begin
            pass_idx_q <= pass_cnt_q;
            if (swap) begin
                frame_id_q <= frame_id_q + 1'b1;
            end
        end
    end

    assign frame_id = frame_id_q;
    assign pass_idx = pass_idx_q;
`endif

endmodule

// File: tb/tb_dft_replay_buffer.sv
// Scoreboard bench: a frame-level model queues every expected replay beat; a negedge monitor pops and compares.
module tb_dft_replay_buffer;

    localparam int F  = 40;
    localparam int N  = 256;
    localparam int IW = 16;
    localparam int OW = 32;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic signed [IW-1:0] bin_re, bin_im;
    logic                 bin_valid, bin_last, bin_ready;
    logic [OW-1:0]        dft_out;
    logic                 dft_valid, replay_busy, sync_err;
`ifdef DFT_REPLAY_FRAME_ID_EN
    logic [7:0]           frame_id;
    logic [$clog2(F)-1:0] pass_idx;
`endif

    dft_replay_buffer #(
        .NUM_MEL_FILTERS (F),
        .NUM_DFT_POINTS  (N),
        .IN_WIDTH        (IW),
        .OUT_WIDTH       (OW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bin_re      (bin_re),
        .bin_im      (bin_im),
        .bin_valid   (bin_valid),
        .bin_last    (bin_last),
        .bin_ready   (bin_ready),
        .dft_out     (dft_out),
        .dft_valid   (dft_valid),
        .replay_busy (replay_busy),
        .sync_err    (sync_err)
`ifdef DFT_REPLAY_FRAME_ID_EN
        ,
        .frame_id    (frame_id),
        .pass_idx    (pass_idx)
`endif
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        longint pwr;
        int     pass;
        int     fid;
        bit     first;
    } exp_t;

    exp_t   exp_q[$];
    longint frame_pwr[N];
    int     fill = 0;
    int     fid_m = 0;
    int     exp_sync = 0;
    int     errors = 0;
    int     checks = 0;
    longint cyc = 0;
    longint acc_cyc = 0;
    longint first_cyc = 0;
    longint first_gap = 0;
    longint last_vld_cyc = -100;
    int     sync_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame-level model: bins fill a frame; a full count completes it, a stray bin_last discards it.
    function automatic void model_accept(input int re, input int im, input bit last);
        longint r = re;
        longint i = im;
        frame_pwr[fill] = r * r + i * i;
        if (fill == N - 1) begin
            if (!last) exp_sync++;
            fid_m++;
            for (int p = 0; p < F; p++) begin
                for (int k = 0; k < N; k++) begin
                    exp_t e;
                    e.pwr   = frame_pwr[k];
                    e.pass  = p;
                    e.fid   = fid_m % 256;
                    e.first = (p == 0 && k == 0);
                    exp_q.push_back(e);
                end
            end
            fill = 0;
        end else if (last) begin
            exp_sync++;
            fill = 0;
        end else begin
            fill++;
        end
    endfunction

    initial forever begin
        @(negedge clk);
        if (sync_err) sync_seen++;
        if (dft_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: dft_out=%0d while no beat is expected (cycle %0d)", dft_out, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("dft_out", dft_out, e.pwr);
`ifdef DFT_REPLAY_FRAME_ID_EN
                check("pass_idx", pass_idx, e.pass);
                check("frame_id", frame_id, e.fid);
`endif
                if (e.first) begin
                    first_cyc = cyc;
                    first_gap = cyc - last_vld_cyc;
                end else begin
                    check("contiguous", cyc - last_vld_cyc, 1);
                end
            end
            last_vld_cyc = cyc;
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!bin_ready && n < 30000) begin
            @(negedge clk);
            n++;
        end
        if (!bin_ready) check("bin_ready_wait", bin_ready, 1);
    endtask

    task automatic send_bin(input int re, input int im, input bit last);
        bin_re    = IW'(re);
        bin_im    = IW'(im);
        bin_last  = last;
        bin_valid = 1'b1;
        wait_ready();
        @(negedge clk);
        acc_cyc = cyc;
        model_accept(re, im, last);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 40000) begin
            @(negedge clk);
            n++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    function automatic int rnd();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    initial begin
        int n;
        int base;
        int re0, im0;
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        int re0, im0;
        rst_n = 1'b0; bin_valid = 1'b1; bin_re = '0; bin_im = '0; bin_last = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_bin_ready", bin_ready, 0);
        check("rst_dft_valid", dft_valid, 0);
        check("rst_replay_busy", replay_busy, 0);
        check("rst_sync_err", sync_err, 0);
        check("rst_dft_out", dft_out, 0);
        rst_n = 1'b1;
        bin_valid = 1'b0;
        @(negedge clk);
        check("ready_after_release", bin_ready, 1);

        // Ramp frame: powers 0,1,4,...,65025 per pass
        for (int k = 0; k < N; k++) send_bin(k, 0, k == N - 1);
        bin_valid = 1'b0;
        wait_drain();
        check("first_latency", first_cyc - acc_cyc, 2);
        repeat (2) @(negedge clk);
        check("idle_dft_valid", dft_valid, 0);
        check("idle_replay_busy", replay_busy, 0);

        // Back-to-back: A (random, with 3,-4), B (all most-negative), then C blocked until B swaps in
        for (int k = 0; k < N; k++)
            send_bin(k == 7 ? 3 : rnd(), k == 7 ? -4 : rnd(), k == N - 1);
        for (int k = 0; k < N; k++) send_bin(-32768, -32768, k == N - 1);
        check("b2b_ready_held", bin_ready, 0);
        re0 = rnd(); im0 = rnd();
        bin_re = IW'(re0); bin_im = IW'(im0); bin_last = 1'b0; bin_valid = 1'b1;
        wait_ready();
        check("swap_after_a_drained", exp_q.size(), F * N);
        check("swap_busy", replay_busy, 1);
        @(negedge clk);
        model_accept(re0, im0, 1'b0);
        for (int k = 1; k < N; k++) send_bin(rnd(), rnd(), k == N - 1);
        bin_valid = 1'b0;
        check("b2b_idle_gap", first_gap, 2);

        // Abort C mid-pass 17
        n = 0;
        while (exp_q.size() > F * N - 17 * N - 30 && n < 40000) begin
            @(negedge clk);
            n++;
        end
        check("reach_pass17", exp_q.size() <= F * N - 17 * N - 30, 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_dft_valid", dft_valid, 0);
        check("midrst_replay_busy", replay_busy, 0);
        check("midrst_dft_out", dft_out, 0);
        exp_q.delete();
        fill = 0;
        fid_m = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("post_rst_dft_valid", dft_valid, 0);
        check("post_rst_busy", replay_busy, 0);
        check("post_rst_ready", bin_ready, 1);

        // Misaligned bin_last at index 100: one sync_err pulse, no replay
        base = sync_seen;
        for (int k = 0; k <= 100; k++) send_bin(rnd(), rnd(), k == 100);
        bin_valid = 1'b0;
        repeat (20) @(negedge clk);
        check("misaligned_sync_cycles", sync_seen - base, 1);
        check("misaligned_no_replay", dft_valid, 0);
        check("misaligned_not_busy", replay_busy, 0);

        // Fresh frame after abort and discard
        for (int k = 0; k < N; k++) send_bin(N - 1 - k, k, k == N - 1);
        bin_valid = 1'b0;
        wait_drain();
        check("fresh_latency", first_cyc - acc_cyc, 2);
        repeat (3) @(negedge clk);
        check("final_dft_valid", dft_valid, 0);
        check("sync_err_total", sync_seen, exp_sync);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dft_replay_buffer.md
Name: dft_replay_buffer

Overview:
- Producer side of the mel filterbank's `dft_out`/`dft_valid` stream.
- Accepts complex FFT bins, computes power |X|^2 and writes one frame into a ping-pong buffer.
- Replays the stored frame NUM_MEL_FILTERS times, NUM_DFT_POINTS beats per pass, one beat per cycle. This matches the filterbank's filter-outer / bin-inner iteration.
- Sits between the FFT core and the mel filterbank in the MFCC front end.

Parameters:
- NUM_MEL_FILTERS, 40, replay passes per frame
- NUM_DFT_POINTS, 256, bins per frame; power of two
- IN_WIDTH, 16, signed width of each FFT real/imag component
- OUT_WIDTH, 32, output power width; must be >= 2*IN_WIDTH

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- bin_re  in  IN_WIDTH  signed FFT real part
- bin_im  in  IN_WIDTH  signed FFT imaginary part
- bin_valid  in  1  input beat valid
- bin_last  in  1  marks last bin of FFT frame
- bin_ready  out  1  input beat accepted when bin_valid & bin_ready
- dft_out  out  OUT_WIDTH  power of current replayed bin, unsigned
- dft_valid  out  1  dft_out valid this cycle
- replay_busy  out  1  replay of a frame in progress
- sync_err  out  1  one-cycle pulse on misaligned bin_last

Behaviour:
- Reset (async): all outputs 0, both banks empty, write pointer 0, read side idle. RAM contents are don't-care.
- Power arithmetic:
  - power = re*re + im*im, computed at full 2*IN_WIDTH+1 precision.
  - Max value 2^(2*IN_WIDTH-1), which fits unsigned in 2*IN_WIDTH bits.
  - Zero-extend to OUT_WIDTH. No saturation is needed.
  - One register stage, then write to bank at the write index.
- Write FSM:
  - W_FILL: bin_ready=1; each accepted beat increments widx.
  - On accept with widx==NUM_DFT_POINTS-1: frame complete, go to W_FULL, bin_ready=0 from the next cycle.
  - bin_last on an accepted beat with widx!=NUM_DFT_POINTS-1: sync_err pulses 1 cycle, widx resets to 0, partial frame discarded. Stay in W_FILL.
  - bin_last absent on index NUM_DFT_POINTS-1: frame still completes on count, and sync_err pulses.
- Bank swap: occurs in the first cycle where write is in W_FULL and read is in R_IDLE.
  - Write bank becomes read bank; write FSM returns to W_FILL on the other bank.
  - The swap cycle counts as R_IDLE, so at least one idle dft_valid cycle separates consecutive frames.
- Read FSM:
  - R_IDLE: dft_valid=0, replay_busy=0.
  - R_REPLAY: replay_busy=1. Read address = bin counter; pass counter runs 0..NUM_MEL_FILTERS-1.
  - Bin counter wraps 0 after NUM_DFT_POINTS-1 and increments the pass counter.
  - After the last bin of the last pass, return to R_IDLE.
  - RAM read is synchronous: dft_valid/dft_out lag the address by 1 cycle.
  - dft_valid is continuous for NUM_MEL_FILTERS*NUM_DFT_POINTS cycles (10240 at defaults). No gaps within a frame.
  - replay_busy falls in the same cycle as the final dft_valid beat's successor.
- Latency: accepted last bin -> first dft_valid = 3 cycles when read is idle: power reg, swap, RAM read.
- Backpressure: with one bank full and the other replaying, bin_ready=0 until the swap. No input is dropped, and the block has no overflow state.
- Reset mid-operation: immediate abort; both banks marked empty, dft_valid drops asynchronously. Partial replays are not resumed.

Optional Feature:
- Macro DFT_REPLAY_FRAME_ID_EN.
- Defined:
  - Adds output frame_id [7:0], which increments (wraps 255->0) at each bank swap.
  - frame_id is held stable for the whole replay; reset value 0.
  - Adds output pass_idx [$clog2(NUM_MEL_FILTERS)-1:0], aligned with dft_out.
- Undefined: neither port exists; behaviour is otherwise identical.

Decomposition:
- Shared package mfcc_pkg:
  - NUM_MEL_FILTERS and NUM_DFT_POINTS defaults.
  - Derived widths MEL_IDX_W = clog2(filters) and BIN_IDX_W = clog2(points).
  - Power-width function.
  - Write/read FSM state enums.
- One sub-module: spectrum_bank_ram.
  - Simple dual-port synchronous RAM, 2*NUM_DFT_POINTS x OUT_WIDTH.
  - Bank select is the address MSB; 1 write port, 1 read port, 1-cycle read latency.

Test Plan:
- Reset: hold rst_n=0 with bin_valid=1 -> bin_ready, dft_valid, replay_busy, sync_err all 0. After release, bin_ready=1 next cycle.
- Single frame with bin k: re=k, im=0, k=0..255, bin_last at 255.
  - Required response: exactly 10240 contiguous dft_valid beats, each pass 0,1,4,...,65025, repeated 40 times.
  - Then dft_valid=0 and replay_busy=0.
- Extremes: all bins re=-32768, im=-32768 -> every dft_out = 0x80000000. Bin re=3, im=-4 -> 25.
- Back-to-back frames at full input rate:
  - Frame 2 completes during replay 1, so bin_ready=0 until replay 1 ends.
  - Frame 2 replay starts after exactly 1 idle cycle.
  - Frame 3's first beat is accepted only after that swap.
- Misaligned bin_last at index 100 -> sync_err high exactly 1 cycle, no replay triggered. The next full 256-bin frame replays correctly.
- rst_n pulsed low mid-pass 17 -> dft_valid=0 immediately. After release, no residual beats occur; a fresh frame replays from pass 0, bin 0.
